// File: rtl/fetch_stage.sv
// fetch_stage: RV32I fetch stage; owns the PC, drives instmem, feeds decode.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (trap misaligned redirects).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        JMP_DO,
    input  logic [31:0] JMP_PC,
    output logic        MEM_STALL,
    output logic        MEM_FLUSH,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_RDEN,
    input  logic [31:0] MEM_OADDR,
    input  logic [31:0] MEM_DOUT,
    input  logic        MEM_VALID,
    input  logic        MEM_LOADING,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_INST,
    output logic        ID_VALID,
    output logic        ID_EXC
);
    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] issued_pc_q, issued_pc_d;
    logic        issued_v_q, issued_v_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        id_exc_q, id_exc_d;
    logic        exc_q, exc_d;
    logic [31:0] jmp_tgt;
    logic        jmp_bad;
    logic        hold;
    logic        idle;
    logic        capture;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign jmp_tgt = JMP_PC;
    assign jmp_bad = JMP_DO && (JMP_PC[1:0] != 2'b00);
`else
    assign jmp_tgt = {JMP_PC[31:2], 2'b00};
    assign jmp_bad = 1'b0;
`endif

    // A redirect always overrides a downstream stall.
    assign hold    = STALL && !JMP_DO;
    assign idle    = MEM_LOADING || (state_q == S_BOOT) || exc_q;
    assign capture = !STALL && !JMP_DO && issued_v_q && MEM_VALID
                     && (MEM_OADDR == issued_pc_q);

    assign MEM_ADDR  = pc_q;
    assign MEM_RDEN  = (state_q != S_BOOT) && !exc_q;
    assign MEM_STALL = hold;
    assign MEM_FLUSH = JMP_DO;

    assign ID_PC    = id_pc_q;
    assign ID_INST  = id_inst_q;
    assign ID_VALID = id_valid_q;
    assign ID_EXC   = id_exc_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (MEM_LOADING) state_d = S_WAIT;
            S_WAIT:  if (!MEM_LOADING) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
        if (JMP_DO) state_d = S_RUN;
    end

    always_comb begin
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        issued_v_d  = issued_v_q;
        exc_d       = exc_q;
        if (JMP_DO) begin
            pc_d       = jmp_tgt;
            issued_v_d = 1'b0;
            exc_d      = jmp_bad;
        end else if (!STALL) begin
            if (idle) begin
                issued_v_d = 1'b0;
            end else begin
                pc_d        = pc_q + PC_STEP;
                issued_pc_d = pc_q;
                issued_v_d  = 1'b1;
            end
        end
    end

    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        id_exc_d   = id_exc_q;
        if (jmp_bad) begin
            id_pc_d    = JMP_PC;
            id_inst_d  = NOP;
            id_valid_d = 1'b1;
            id_exc_d   = 1'b1;
        end else if (!hold) begin
            id_exc_d   = 1'b0;
            id_valid_d = capture;
            if (capture) begin
                id_pc_d   = MEM_OADDR;
                id_inst_d = MEM_DOUT;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            issued_pc_q <= 32'h0;
            issued_v_q  <= 1'b0;
            exc_q       <= 1'b0;
            id_pc_q     <= 32'h0;
            id_inst_q   <= NOP;
            id_valid_q  <= 1'b0;
            id_exc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            issued_v_q  <= issued_v_d;
            exc_q       <= exc_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_valid_q  <= id_valid_d;
            id_exc_q    <= id_exc_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: random + directed bench for fetch_stage against a
// stream-level model (next expected PC, stall hold, redirect bubble).
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        STALL = 1'b0;
    logic        JMP_DO = 1'b0;
    logic [31:0] JMP_PC = 32'h0;
    logic        MEM_STALL, MEM_FLUSH, MEM_RDEN, MEM_LOADING;
    logic [31:0] MEM_ADDR;
    logic [31:0] ID_PC, ID_INST;
    logic        ID_VALID, ID_EXC;

    logic [31:0] c_oaddr = 32'h0;
    logic [31:0] c_dout = 32'h0;
    logic        c_valid = 1'b0;
    logic [1:0]  cold = 2'b11;
    int          refill = 0;
    int          rpg = 0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_pc, h_pc, h_inst;
    logic        h_valid;
    logic        exc_mode = 1'b0;
    int          quiet;
    int          n;

    always #5 CLK = ~CLK;

    fetch_stage #(.RESET_PC(32'h100), .PC_STEP(32'd4)) dut (
        .CLK(CLK), .RST(RST), .STALL(STALL),
        .JMP_DO(JMP_DO), .JMP_PC(JMP_PC),
        .MEM_STALL(MEM_STALL), .MEM_FLUSH(MEM_FLUSH),
        .MEM_ADDR(MEM_ADDR), .MEM_RDEN(MEM_RDEN),
        .MEM_OADDR(c_oaddr), .MEM_DOUT(c_dout),
        .MEM_VALID(c_valid), .MEM_LOADING(MEM_LOADING),
        .ID_PC(ID_PC), .ID_INST(ID_INST),
        .ID_VALID(ID_VALID), .ID_EXC(ID_EXC)
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Behavioural instruction cache: pages 0x2000 and 0x3000 start cold.
    wire pg2  = (MEM_ADDR[31:12] == 20'h2);
    wire pg3  = (MEM_ADDR[31:12] == 20'h3);
    wire miss = MEM_RDEN && ((pg2 && cold[0]) || (pg3 && cold[1]));
    assign MEM_LOADING = (refill != 0) || miss;

    always @(posedge CLK) begin
        if (refill > 1) begin
            refill <= refill - 1;
        end else if (refill == 1) begin
            refill <= 0;
            cold[rpg] <= 1'b0;
        end else if (miss) begin
            refill <= 40;
            rpg <= pg3 ? 1 : 0;
        end
        if (MEM_FLUSH) begin
            c_valid <= 1'b0;
        end else if (!MEM_STALL) begin
            if (MEM_RDEN && !MEM_LOADING) begin
                c_oaddr <= MEM_ADDR;
                c_dout  <= memw(MEM_ADDR);
                c_valid <= 1'b1;
            end else begin
                c_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc   = 32'h100;
        quiet    = -1;
        h_pc     = 32'h0;
        h_inst   = NOP;
        h_valid  = 1'b0;
        exc_mode = 1'b0;
    endtask

    // One cycle: drive at negedge, check combinational outputs, then
    // sample the registered outputs at the next negedge.
    task automatic step(input logic st, input logic jd, input logic [31:0] jp);
        logic ld;
        logic bad;
        STALL  = st;
        JMP_DO = jd;
        JMP_PC = jp;
        #1;
        check("mem_stall", MEM_STALL, st && !jd);
        check("mem_flush", MEM_FLUSH, jd);
        ld  = MEM_LOADING;
        bad = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        bad = jd && (jp[1:0] != 2'b00);
`endif
        @(negedge CLK);
        STALL  = 1'b0;
        JMP_DO = 1'b0;
        if (bad) begin
            check("exc_valid", ID_VALID, 1);
            check("exc_pc", ID_PC, jp);
            check("exc_inst", ID_INST, NOP);
            check("exc_flag", ID_EXC, 1);
            exc_mode = 1'b1;
            quiet = 0;
        end else if (jd) begin
            check("redir_bubble", ID_VALID, 0);
            check("exc_clr", ID_EXC, 0);
            exp_pc   = {jp[31:2], 2'b00};
            quiet    = 0;
            exc_mode = 1'b0;
        end else if (st) begin
            check("stall_hold_pc", ID_PC, h_pc);
            check("stall_hold_inst", ID_INST, h_inst);
            check("stall_hold_valid", ID_VALID, h_valid);
            quiet = 0;
        end else begin
            check("exc_clr", ID_EXC, 0);
            if (ld) quiet = 0;
            else quiet++;
            if (quiet >= 2 && !exc_mode) check("stream_gap", ID_VALID, 1);
            if (exc_mode) check("exc_idle_rden", MEM_RDEN, 0);
            if (ID_VALID) begin
                check("stream_pc", ID_PC, exp_pc);
                check("stream_inst", ID_INST, memw(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
        end
        h_pc    = ID_PC;
        h_inst  = ID_INST;
        h_valid = ID_VALID;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge CLK);
        check("rst_valid", ID_VALID, 0);
        check("rst_pc", ID_PC, 32'h0);
        check("rst_inst", ID_INST, NOP);
        check("rst_exc", ID_EXC, 0);
        check("rst_rden", MEM_RDEN, 0);
        check("rst_addr", MEM_ADDR, 32'h100);
        RST = 1'b0;
        #1;
        check("boot_rden", MEM_RDEN, 0);

        repeat (3) step(0, 0, 0);
        check("first_valid", ID_VALID, 1);
        check("first_pc", ID_PC, 32'h100);
        repeat (2) step(0, 0, 0);
        check("seq_pc", ID_PC, 32'h108);

        repeat (3) step(1, 0, 0);
        check("stall_pc", ID_PC, 32'h108);
        step(0, 0, 0);
        check("after_stall_pc", ID_PC, 32'h10C);
        check("after_stall_valid", ID_VALID, 1);

        step(0, 1, 32'h40);
        step(0, 0, 0);
        check("fill_bubble", ID_VALID, 0);
        step(0, 0, 0);
        check("redir_pc", ID_PC, 32'h40);
        step(0, 0, 0);
        check("redir_next", ID_PC, 32'h44);

        step(1, 1, 32'h80);
        repeat (2) step(0, 0, 0);
        check("jmp_stall_pc", ID_PC, 32'h80);

        step(0, 1, 32'h2000);
        n = 0;
        while (!ID_VALID && n < 100) begin
            if (MEM_LOADING) begin
                check("cold_addr", MEM_ADDR, 32'h2000);
            end
            step(0, 0, 0);
            n++;
        end
        check("cold_wait", n >= 40, 1);
        check("cold_pc", ID_PC, 32'h2000);
        step(0, 0, 0);
        check("cold_next", ID_PC, 32'h2004);

        step(0, 1, 32'hFFFF_FFF8);
        repeat (2) step(0, 0, 0);
        check("wrap_first", ID_PC, 32'hFFFF_FFF8);
        repeat (2) step(0, 0, 0);
        check("wrap_zero", ID_PC, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
        step(0, 1, 32'h42);
        repeat (3) step(0, 0, 0);
        check("exc_idle_valid", ID_VALID, 0);
        step(0, 1, 32'h40);
        repeat (2) step(0, 0, 0);
        check("exc_recover", ID_PC, 32'h40);
`else
        step(0, 1, 32'h303);
        repeat (2) step(0, 0, 0);
        check("misalign_ignored", ID_PC, 32'h300);
`endif

        step(0, 1, 32'h3000);
        repeat (10) step(0, 0, 0);
        check("refill_busy", MEM_LOADING, 1);
        #2;
        RST = 1'b1;
        #1;
        check("arst_valid", ID_VALID, 0);
        check("arst_addr", MEM_ADDR, 32'h100);
        check("arst_inst", ID_INST, NOP);
        check("arst_rden", MEM_RDEN, 0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        n = 0;
        while (!ID_VALID && n < 200) begin
            step(0, 0, 0);
            n++;
        end
        check("arst_resume_pc", ID_PC, 32'h100);

        for (int i = 0; i < 3000; i++) begin
            logic        s;
            logic        j;
            logic [31:0] t;
            s = ($urandom_range(0, 5) == 0);
            j = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                t = 32'hFFFF_FFE0 | ($urandom & 32'h1C);
            else
                t = $urandom & 32'h0000_3FFC;
`ifndef FETCH_MISALIGN_CHECK_EN
            t[1:0] = 2'($urandom);
`endif
            step(s, j, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
